wb_queue: RTL
=============

# wb_queue

Writeback queue that drives the write port of the CPU register file. It accepts results from the ALU path and the memory-load path, buffers them in a small in-order FIFO, and issues at most one register write (`wrt`/`rd`/`din`) per clock. It also answers two register-number lookups from decode with the youngest pending value, so that reads are not stale while writes are still queued.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `AW`, 6: register-number width (64 registers).
- `DW`, 32: data width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_valid`  in  1  load result present this cycle.
- `mem_rd`  in  AW  load destination register.
- `mem_data`  in  DW  load result.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_rd`  in  AW  ALU destination register.
- `alu_data`  in  DW  ALU result.
- `in_ready`  out  1  high when at least 2 entries are free.
- `wrt`  out  1  register-file write enable.
- `rd`  out  AW  register-file write address.
- `din`  out  DW  register-file write data.
- `q_rs`, `q_rt`  in  AW  lookup register numbers.
- `s_hit`, `t_hit`  out  1  a pending entry matches `q_rs` / `q_rt`.
- `s_data`, `t_data`  out  DW  data of the youngest matching entry; 0 when there is no hit.
- `count`  out  clog2(DEPTH)+1  number of occupied entries.
- `empty`, `full`  out  1  `count`==0 / `count`==DEPTH.

## Operation
- **Storage:** circular buffer of {rd, data}, with head pointer, tail pointer and count. Both pointers wrap modulo DEPTH.
- **Enqueue:**
  - A valid input is accepted only in a cycle where `in_ready`=1.
  - When both inputs are valid, the mem entry is written first (it is the older instruction) and the ALU entry second, both on the same edge.
  - Valid inputs while `in_ready`=0 are dropped. This is a protocol violation; upstream must stall on `in_ready`=0.
- **Drain:**
  - `wrt`=!`empty`.
  - `rd` and `din` are taken combinationally from the head entry.
  - Every edge with `wrt`=1 pops the head. The register file captures the write on that same edge, so there is no backpressure from the register file.
  - While `empty`: `rd`=0 and `din`=0.
- **Simultaneous push and pop:** count(next) = count + pushes − (`wrt`?1:0). The pop and up to 2 pushes happen on the same edge.
- **Lookup:**
  - A combinational search over the occupied entries only.
  - When several entries match, the youngest (closest to the tail) wins.
  - Entries being enqueued in the current cycle are not visible to the lookup.
  - The head entry is visible until the edge that pops it.
- **rd=0:** no special case; it is queued and written like any other register.
- **Reset:**
  - On `rst`=1, asynchronously: count=0, head=0, tail=0.
  - Therefore `wrt`=0, `rd`=0, `din`=0, `s_hit`=`t_hit`=0, `s_data`=`t_data`=0, `empty`=1, `full`=0, `in_ready`=1.
  - Entry contents are not cleared.
  - Reset mid-operation discards all pending writes; none are issued after reset.

## Timing
- **Write latency when the queue is empty:** an input accepted at edge N gives `wrt`=1 with that entry during cycle N→N+1. The register file writes it at edge N+1.
- **Throughput:** 1 write per cycle out; up to 2 entries per cycle in.
- **Queue growth:** sustained dual input raises count by 1 per cycle. `in_ready` falls once count > DEPTH−2.
- **Combinational paths:**
  - `in_ready`, `full`, `empty` and `count` depend only on registered state.
  - The lookup path runs from `q_rs`/`q_rt` to the hit/data outputs.

## Test plan
- **Reset values:** assert `rst` mid-stream with count=3 → the same cycle shows `wrt`=0, `empty`=1, `in_ready`=1. After release, no write is issued.
- **Single ALU write:** `alu_valid`, `alu_rd`=5, `alu_data`=0x1234 for one cycle → next cycle shows `wrt`=1, `rd`=5, `din`=0x1234. The cycle after that shows `wrt`=0.
- **Dual input ordering:** mem (rd=3, data 0xA) and ALU (rd=3, data 0xB) valid in the same cycle → writes are issued as 0xA then 0xB. During the first write cycle, `q_rs`=3 gives `s_hit`=1 and `s_data`=0xB.
- **Fill and backpressure:** dual input every cycle with DEPTH=4 → `in_ready` drops once count reaches 3. Count never exceeds 4. The drain order matches the input order exactly across pointer wrap-around.
- **Lookup miss:** queue holds rd=7 only; `q_rt`=8 → `t_hit`=0 and `t_data`=0. `q_rt`=7 → `t_hit`=1 until the edge where rd=7 is written.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: writeback queue feeding the register-file write port.
// Buffers ALU and load results in an in-order circular FIFO.
// Issues one register write per clock from the head entry.
// Answers two register-number lookups with the youngest pending value.
module wb_queue #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 6,
  parameter  int DW    = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          in_ready,
  output logic          wrt,
  output logic [AW-1:0] rd,
  output logic [DW-1:0] din,
  input  logic [AW-1:0] q_rs,
  input  logic [AW-1:0] q_rt,
  output logic          s_hit,
  output logic          t_hit,
  output logic [DW-1:0] s_data,
  output logic [DW-1:0] t_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push_mem, push_alu, pop;
  logic [PW-1:0] alu_slot;

  // Status flags come from registered state only.
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = (count_q <= CW'(DEPTH - 2));

  // Inputs arriving while not ready are dropped; mem is the older instruction.
  assign push_mem = mem_valid & in_ready;
  assign push_alu = alu_valid & in_ready;
  assign alu_slot = tail_q + PW'(push_mem);

  // The register file accepts every write, so a non-empty queue always pops.
  assign pop = !empty;
  assign wrt = pop;
  assign rd  = pop ? rd_mem[head_q]   : '0;
  assign din = pop ? data_mem[head_q] : '0;

  // Next-state pointers and occupancy for simultaneous push and pop.
  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push_mem) + PW'(push_alu);
    count_d = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; mem takes the tail slot, ALU the one after it.
  // NOTE: storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_mem) begin
      rd_mem[tail_q]   <= mem_rd;
      data_mem[tail_q] <= mem_data;
    end
    if (push_alu) begin
      rd_mem[alu_slot]   <= alu_rd;
      data_mem[alu_slot] <= alu_data;
    end
  end

  // Lookup over occupied entries, oldest to youngest, so the youngest match wins.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    s_hit  = 1'b0;
    s_data = '0;
    t_hit  = 1'b0;
    t_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (rd_mem[head_q + PW'(i)] == q_rs) begin
          s_hit  = 1'b1;
          s_data = data_mem[head_q + PW'(i)];
        end
        if (rd_mem[head_q + PW'(i)] == q_rt) begin
          t_hit  = 1'b1;
          t_data = data_mem[head_q + PW'(i)];
        end
      end
    end
  end

endmodule
